adder_share_ctrl: RTL

Controller that time-shares the single 32-bit ripple adder in the datapath between two requesters: the PC-increment unit (PC + 1) and the branch-target unit (PC + sign-extended 16-bit offset). It arbitrates requests round-robin, sign-extends the branch immediate, and drives the adder operands from registers. It captures the sum and holds it with an ID tag until the consumer acknowledges. The block sits between fetch/decode and the shared adder.

---
 rtl/adder_share_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//
// Time-shares one external WIDTH-bit adder between two requesters:
//   - the PC-increment unit (computes pc_a + 1)
//   - the branch-target unit (computes br_a + sign-extended br_imm)
// When both requesters ask at once, a round-robin pointer picks the winner.
// The operands are registered towards the adder. The sum is captured one cycle
// later and held with an ID tag until the consumer acknowledges it.
//
// Ports:
//   clk_i, reset_i        clock; synchronous active-high reset
//   pc_req_i, pc_a_i      PC-increment request and current PC
//   pc_ready_o            combinational grant to the PC-increment requester
//   br_req_i, br_a_i,     branch-target request, PC base and signed offset
//   br_imm_i
//   br_ready_o            combinational grant to the branch-target requester
//   add_a_o, add_b_o      registered operands driven to the shared adder
//   add_sum_i             combinational sum returned by the shared adder
//   res_valid_o           a captured result is being presented
//   res_id_o              0 = PC-increment result, 1 = branch-target result
//   res_data_o            captured sum
//   res_ack_i             consumer accepts the result while res_valid_o is high
module adder_share_ctrl #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pc_req_i,
    input  logic [WIDTH-1:0] pc_a_i,
    output logic             pc_ready_o,
    input  logic             br_req_i,
    input  logic [WIDTH-1:0] br_a_i,
    input  logic [IMM_W-1:0] br_imm_i,
    output logic             br_ready_o,
    output logic [WIDTH-1:0] add_a_o,
    output logic [WIDTH-1:0] add_b_o,
    input  logic [WIDTH-1:0] add_sum_i,
    output logic             res_valid_o,
    output logic             res_id_o,
    output logic [WIDTH-1:0] res_data_o,
    input  logic             res_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] addA_q, addA_d;
    logic [WIDTH-1:0] addB_q, addB_d;
    logic [WIDTH-1:0] resData_q, resData_d;
    logic             resId_q, resId_d;
    logic             grantPc, grantBr;
    logic [WIDTH-1:0] brImmExt;

    // The branch offset is signed, so its top bit is replicated up to the full width.
    assign brImmExt = {{(WIDTH-IMM_W){br_imm_i[IMM_W-1]}}, br_imm_i};

    // This block decides the grant and computes the next state.
    // Grants are issued only in IDLE and are gated off while reset is high.
    // A contested grant goes to the requester that prio_q points at
    // (0 = pc, 1 = br). The pointer then moves to the requester that lost.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        addA_d    = addA_q;
        addB_d    = addB_q;
        resData_d = resData_q;
        resId_d   = resId_q;
        grantPc   = 1'b0;
        grantBr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset_i) begin
                    grantPc = pc_req_i && (!br_req_i || !prio_q);
                    grantBr = br_req_i && (!pc_req_i || prio_q);
                end
                if (grantPc) begin
                    addA_d  = pc_a_i;
                    addB_d  = WIDTH'(1);
                    resId_d = 1'b0;
                    prio_d  = 1'b1;
                    state_d = ADD;
                end else if (grantBr) begin
                    addA_d  = br_a_i;
                    addB_d  = brImmExt;
                    resId_d = 1'b1;
                    prio_d  = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // The adder is purely combinational, so its sum is valid one cycle after the operands are registered.
                resData_d = add_sum_i;
                state_d   = RESP;
            end
            RESP: begin
                if (res_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // This block holds the state, the round-robin pointer, the operand registers and the result registers.
    // Reset discards any in-flight result.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            addA_q    <= '0;
            addB_q    <= '0;
            resData_q <= '0;
            resId_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            addA_q    <= addA_d;
            addB_q    <= addB_d;
            resData_q <= resData_d;
            resId_q   <= resId_d;
        end
    end

    assign pc_ready_o  = grantPc;
    assign br_ready_o  = grantBr;
    assign add_a_o     = addA_q;
    assign add_b_o     = addB_q;
    assign res_valid_o = (state_q == RESP);
    assign res_id_o    = resId_q;
    assign res_data_o  = resData_q;

endmodule
